// File: rtl/leading_ones_mask.sv
// -----------------------------------------------------------------------------
// leading_ones_mask
//
// Multi-cycle custom instruction that builds a contiguous mask of ones. It is
// the inverse of count-leading-ones: given a count c, it returns c ones packed
// against the MSB (n=0) or against the LSB (n=1). Counts of size or more give
// an all-ones word.
//
// One mask bit is shifted into the accumulator per enabled cycle, so a start
// accepted in cycle T completes with done=1 in cycle T+c+2.
//
// Ports
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset; wins over clk_en and start
//   clk_en  : clock qualifier; when low, every register holds
//   start   : one-cycle start pulse, honoured only in IDLE
//   dataa   : requested ones count (unsigned, saturated to size)
//   n       : 0 = ones from the MSB downward, 1 = ones from the LSB upward
//   done    : registered one-cycle completion pulse
//   result  : registered mask; holds until the next completion
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; count, mode and accumulator loaded on start
// SHIFT | one ones bit shifted into acc per cycle until cnt reaches 0
// DONE  | done high for this one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module leading_ones_mask #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            start,
    input  logic [size-1:0] dataa,
    input  logic            n,
    output logic            done,
    output logic [size-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [size-1:0] SAT_MAX = size;
    localparam logic [5:0]      CNT_MAX = 6'd32;

    state_t          state_q;
    logic [5:0]      cnt_q;
    logic [size-1:0] acc_q;
    logic [size-1:0] result_q;
    logic            mode_q;
    logic            done_q;

    // Saturation has to look at the whole word: a value such as 32'h8000_0000
    // has zero low bits but still means "all ones".
    logic [5:0] sat_cnt;
    assign sat_cnt = (dataa >= SAT_MAX) ? CNT_MAX : dataa[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= sat_cnt;
                        mode_q  <= n;
                        acc_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != 6'd0) begin
                        if (mode_q) begin
                            acc_q <= {acc_q[size-2:0], 1'b1};
                        end else begin
                            acc_q <= {1'b1, acc_q[size-1:1]};
                        end
                        cnt_q <= cnt_q - 6'd1;
                    end else begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
